// File: rtl/pa2se_tx.sv
// Parallel-to-serial framer: captures 8 complex channels per frame, rounds and
// saturates them, and streams them one sample per handshake to the IFFT.
module pa2se_tx #(
  parameter int IN_W  = 20,
  parameter int OUT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_W-1:0]      tx_sig_real [8],
  input  logic [IN_W-1:0]      tx_sig_imag [8],
  input  logic [7:0]           tx_sig_tvalid,
  output logic                 tx_ready,
  output logic [2*OUT_W-1:0]   ifft_m_data_tdata,
  output logic [2:0]           ifft_m_data_tuser,
  output logic                 ifft_m_data_tvalid,
  output logic                 ifft_m_data_tlast,
  input  logic                 ifft_m_data_tready,
  input  logic                 err_clr,
  output logic                 overflow_err,
  output logic                 partial_err
);

  localparam int SH = IN_W - OUT_W;
  localparam logic signed [IN_W:0] RND  = (IN_W+1)'(1 << (SH - 1));
  localparam logic signed [IN_W:0] MAXV = (IN_W+1)'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [IN_W:0] MINV = ~MAXV;

  typedef enum logic {IDLE, STREAM} state_t;

  // Round half up, then clamp to the signed output range.
  function automatic logic [OUT_W-1:0] quant(input logic [IN_W-1:0] x);
    logic signed [IN_W:0] sum;
    logic signed [IN_W:0] shifted;
    sum     = $signed({x[IN_W-1], x}) + RND;
    shifted = sum >>> SH;
    if (shifted > MAXV)
      quant = MAXV[OUT_W-1:0];
    else if (shifted < MINV)
      quant = MINV[OUT_W-1:0];
    else
      quant = shifted[OUT_W-1:0];
  endfunction

  logic [2*OUT_W-1:0] slot_mem [2][8];
  logic [2*OUT_W-1:0] q_word [8];

  state_t     state_reg;
  logic [1:0] occ_reg;
  logic [1:0] occ_next;
  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [2:0] idx_reg;
  logic [2:0] idx_next;
  logic       tlast_reg;
  logic       overflow_reg;
  logic       partial_reg;

  logic frame_all;
  logic frame_partial;
  logic accept;
  logic handshake;
  logic release_slot;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_quant
      assign q_word[gi] = {quant(tx_sig_imag[gi]), quant(tx_sig_real[gi])};
    end
  endgenerate

  assign frame_all     = (tx_sig_tvalid == 8'hFF);
  assign frame_partial = (tx_sig_tvalid != 8'hFF) && (tx_sig_tvalid != 8'h00);
  assign tx_ready      = (occ_reg != 2'd2);
  assign accept        = frame_all && tx_ready;
  assign handshake     = (state_reg == STREAM) && ifft_m_data_tready;
  assign release_slot  = handshake && (idx_reg == 3'd7);

  always_comb begin
    occ_next = occ_reg;
    case ({accept, release_slot})
      2'b10:   occ_next = occ_reg + 2'd1;
      2'b01:   occ_next = occ_reg - 2'd1;
      default: occ_next = occ_reg;
    endcase
    idx_next = handshake ? idx_reg + 3'd1 : idx_reg;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < 8; k++)
        slot_mem[wr_ptr_reg][k] <= q_word[k];
    end
  end

  // The streaming state follows the post-edge occupancy, so an accept from IDLE
  // and a release with another frame queued both present a sample next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      occ_reg      <= 2'd0;
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      idx_reg      <= 3'd0;
      tlast_reg    <= 1'b0;
      overflow_reg <= 1'b0;
      partial_reg  <= 1'b0;
    end else begin
      occ_reg <= occ_next;
      idx_reg <= idx_next;
      if (accept)
        wr_ptr_reg <= ~wr_ptr_reg;
      if (release_slot)
        rd_ptr_reg <= ~rd_ptr_reg;
      state_reg <= (occ_next != 2'd0) ? STREAM : IDLE;
      tlast_reg <= (occ_next != 2'd0) && (idx_next == 3'd7);

      if (frame_all && !tx_ready)
        overflow_reg <= 1'b1;
      else if (err_clr)
        overflow_reg <= 1'b0;
      if (frame_partial)
        partial_reg <= 1'b1;
      else if (err_clr)
        partial_reg <= 1'b0;
    end
  end

  assign ifft_m_data_tvalid = (state_reg == STREAM);
  assign ifft_m_data_tuser  = idx_reg;
  assign ifft_m_data_tlast  = tlast_reg;
  assign ifft_m_data_tdata  = (state_reg == STREAM) ? slot_mem[rd_ptr_reg][idx_reg] : '0;
  assign overflow_err       = overflow_reg;
  assign partial_err        = partial_reg;

endmodule
